// File: rtl/reduce_pipe.sv
// reduce_pipe: parametrised wire / reduce / register building block.
//
// Purpose:
//   Copies a WIDTH-bit vector straight through and forms a combinational
//   reduction of it (AND / OR / XOR / NAND). The same reduction is carried
//   through a DEPTH-stage pipeline together with a valid bit. The pipeline
//   advances only while en=1. A rising-edge detector watches the valid
//   results leaving the pipeline, and an optional saturating counter
//   counts the detected rising edges.
//
// Build option:
//   REDUCE_PIPE_EVENT_CNT_EN - when defined, the CNT_W-bit saturating rise
//   counter is built. When undefined, no counter flops exist and cnt reads 0.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (has priority over en)
//   en       pipeline advance; 0 stalls every register
//   mode     reduction select: 00 AND, 01 OR, 10 XOR, 11 NAND
//   i        data vector
//   i_valid  marks i as a valid sample
//   o0       wire copy of i
//   o1       combinational reduction of i under the current mode
//   o2       pipelined reduction (last stage)
//   o2_valid valid bit travelling with o2
//   rise     one-cycle pulse on a valid 0->1 transition of o2
//   cnt      saturating count of rise pulses
module reduce_pipe #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o0,
    output logic             o1,
    output logic             o2,
    output logic             o2_valid,
    output logic             rise,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    logic             red_c;
    logic [DEPTH-1:0] pipe_d;
    logic [DEPTH-1:0] pipe_v;
    logic [DEPTH-1:0] nxt_d;
    logic [DEPTH-1:0] nxt_v;
    logic             enter_d;
    logic             enter_v;
    logic             last_o2;
    logic             rise_set_c;

    // Reduction of the live input under the current mode
    always_comb begin
        red_c = 1'b0;
        case (mode)
            MODE_AND:  red_c = &i;
            MODE_OR:   red_c = |i;
            MODE_XOR:  red_c = ^i;
            MODE_NAND: red_c = ~(&i);
            default:   red_c = 1'b0;
        endcase
    end

    assign o0 = i;
    assign o1 = red_c;

    // Next pipeline contents when advancing; a single stage has no shift part
    if (DEPTH == 1) begin : g_single
        assign nxt_d = red_c;
        assign nxt_v = i_valid;
    end else begin : g_multi
        assign nxt_d = {pipe_d[DEPTH-2:0], red_c};
        assign nxt_v = {pipe_v[DEPTH-2:0], i_valid};
    end

    // Sample about to land in the last stage on an advancing edge
    assign enter_d = nxt_d[DEPTH-1];
    assign enter_v = nxt_v[DEPTH-1];

    // Pipeline stages; mode is frozen into the data bit at capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_d <= '0;
            pipe_v <= '0;
        end else if (en) begin
            pipe_d <= nxt_d;
            pipe_v <= nxt_v;
        end
    end

    assign o2       = pipe_d[DEPTH-1];
    assign o2_valid = pipe_v[DEPTH-1];

    // Rising edge: valid 1 entering the last stage after a remembered valid 0
    assign rise_set_c = enter_v & enter_d & ~last_o2;

    // Edge detector; invalid samples never touch last_o2
    always_ff @(posedge clk) begin
        if (rst) begin
            last_o2 <= 1'b0;
            rise    <= 1'b0;
        end else begin
            rise <= en & rise_set_c;
            if (en && enter_v) begin
                last_o2 <= enter_d;
            end
        end
    end

`ifdef REDUCE_PIPE_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating rise counter, stepped on the same edge that raises rise
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en && rise_set_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_reduce_pipe.sv
// Bench for reduce_pipe. It runs two instances on shared stimulus: a main one
// with CNT_W=8 and a narrow one with CNT_W=2 that exercises counter
// saturation. A queue scoreboard models the pipeline, and scenario tasks add
// targeted checks of their own.
module tb_reduce_pipe;

    localparam int unsigned WIDTH  = 3;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CNT_WS = 2;

`ifdef REDUCE_PIPE_EVENT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  i;
    logic              i_valid;

    logic [WIDTH-1:0]  o0, s_o0;
    logic              o1, s_o1;
    logic              o2, s_o2;
    logic              o2_valid, s_o2_valid;
    logic              rise, s_rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_WS-1:0] s_cnt;

    int errors = 0;
    int checks = 0;

    reduce_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i), .i_valid(i_valid),
        .o0(o0), .o1(o1), .o2(o2), .o2_valid(o2_valid), .rise(rise), .cnt(cnt)
    );

    reduce_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_WS)) dut_s (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i), .i_valid(i_valid),
        .o0(s_o0), .o1(s_o1), .o2(s_o2), .o2_valid(s_o2_valid), .rise(s_rise), .cnt(s_cnt)
    );

    always #5 clk = ~clk;

    // Reference reduction built from a population count
    function automatic logic ref_reduce(input logic [1:0] m, input logic [WIDTH-1:0] v);
        int ones;
        ones = 0;
        for (int b = 0; b < int'(WIDTH); b++) if (v[b]) ones++;
        case (m)
            2'b00:   return ones == int'(WIDTH);
            2'b01:   return ones != 0;
            2'b10:   return (ones % 2) == 1;
            default: return ones != int'(WIDTH);
        endcase
    endfunction

    function automatic int sat_inc(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c < mx) ? c + 1 : c;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        int c;
        c = (n > 255) ? 255 : n;
        return CNT_ON ? CNT_W'(c) : '0;
    endfunction

    function automatic logic [CNT_WS-1:0] exp_cnt_s(input int n);
        int c;
        c = (n > 3) ? 3 : n;
        return CNT_ON ? CNT_WS'(c) : '0;
    endfunction

    // Scoreboard: queue front is the last stage; each advancing edge pushes the
    // newly captured sample and pops the oldest one.
    logic [1:0] sbq[$];
    bit         mon_on = 1'b0;
    logic       m_last = 1'b0;
    logic       m_rise = 1'b0;
    int         m_cnt = 0;
    int         m_cnt_s = 0;
    logic [1:0] head;
    logic [CNT_W-1:0]  e_cnt;
    logic [CNT_WS-1:0] e_cnt_s;

    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
            for (int k = 0; k < int'(DEPTH); k++) sbq.push_back(2'b00);
            m_last  = 1'b0;
            m_rise  = 1'b0;
            m_cnt   = 0;
            m_cnt_s = 0;
            mon_on  = 1'b1;
        end else if (mon_on) begin
            if (en) begin
                sbq.push_back({ref_reduce(mode, i), i_valid});
                void'(sbq.pop_front());
                head   = sbq[0];
                m_rise = head[0] & head[1] & ~m_last;
                if (head[0]) m_last = head[1];
                if (m_rise) begin
                    m_cnt   = sat_inc(m_cnt, int'(CNT_W));
                    m_cnt_s = sat_inc(m_cnt_s, int'(CNT_WS));
                end
            end else begin
                m_rise = 1'b0;
            end
        end
        if (mon_on) begin
            #1;
            head    = sbq[0];
            e_cnt   = CNT_ON ? CNT_W'(m_cnt) : '0;
            e_cnt_s = CNT_ON ? CNT_WS'(m_cnt_s) : '0;
            checks++;
            if (o2 !== head[1]) begin errors++; $display("FAIL sb_o2 t=%0t got=%b exp=%b", $time, o2, head[1]); end
            checks++;
            if (o2_valid !== head[0]) begin errors++; $display("FAIL sb_o2_valid t=%0t got=%b exp=%b", $time, o2_valid, head[0]); end
            checks++;
            if (rise !== m_rise) begin errors++; $display("FAIL sb_rise t=%0t got=%b exp=%b", $time, rise, m_rise); end
            checks++;
            if (cnt !== e_cnt) begin errors++; $display("FAIL sb_cnt t=%0t got=%0d exp=%0d", $time, cnt, e_cnt); end
            checks++;
            if (s_cnt !== e_cnt_s) begin errors++; $display("FAIL sb_cnt_sat t=%0t got=%0d exp=%0d", $time, s_cnt, e_cnt_s); end
            checks++;
            if ({s_o2, s_o2_valid, s_rise} !== {head[1], head[0], m_rise}) begin
                errors++;
                $display("FAIL sb_narrow t=%0t got=%b exp=%b", $time, {s_o2, s_o2_valid, s_rise}, {head[1], head[0], m_rise});
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [WIDTH-1:0] v, input logic iv);
        rst = r; en = e; mode = m; i = v; i_valid = iv;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o0 !== 3'b111) begin errors++; $display("FAIL reset_o0 got=%b exp=111", o0); end
            checks++;
            if (o1 !== 1'b1) begin errors++; $display("FAIL reset_o1 got=%b exp=1", o1); end
            checks++;
            if ({o2, o2_valid, rise} !== 3'b000) begin errors++; $display("FAIL reset_outs got=%b exp=000", {o2, o2_valid, rise}); end
            checks++;
            if (cnt !== '0 || s_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt, s_cnt); end
        end
    endtask

    task automatic test_and_single();
        int rises;
        rises = 0;
        drive(1'b0, 1'b1, 2'b00, 3'b111, 1'b1);
        #1;
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL and_o1_now got=%b exp=1", o1); end
        @(negedge clk);
        checks++;
        if (o2_valid !== 1'b0) begin errors++; $display("FAIL and_early_valid got=%b exp=0", o2_valid); end
        drive(1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
        #1;
        checks++;
        if (o1 !== 1'b0) begin errors++; $display("FAIL and_o1_zero got=%b exp=0", o1); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rise) rises++;
            if (c == 0) begin
                checks++;
                if ({o2, o2_valid, rise} !== 3'b111) begin errors++; $display("FAIL and_out got=%b exp=111", {o2, o2_valid, rise}); end
                checks++;
                if (cnt !== exp_cnt(1)) begin errors++; $display("FAIL and_cnt got=%0d exp=%0d", cnt, exp_cnt(1)); end
            end
        end
        checks++;
        if (rises != 1) begin errors++; $display("FAIL and_rise_count got=%0d exp=1", rises); end
    endtask

    task automatic test_xor_seq();
        logic [WIDTH-1:0] vec [3];
        logic got [6];
        logic gotv [6];
        int rises;
        vec = '{3'b001, 3'b011, 3'b111};
        rises = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive(1'b0, 1'b1, 2'b10, vec[k], 1'b1);
            else       drive(1'b0, 1'b1, 2'b10, 3'b000, 1'b0);
            @(negedge clk);
            got[k]  = o2;
            gotv[k] = o2_valid;
            if (rise) rises++;
        end
        checks++;
        if ({got[1], got[2], got[3]} !== 3'b101 || {gotv[1], gotv[2], gotv[3]} !== 3'b111) begin
            errors++;
            $display("FAIL xor_seq got=%b valid=%b exp=101 valid=111", {got[1], got[2], got[3]}, {gotv[1], gotv[2], gotv[3]});
        end
        checks++;
        if (rises != 2) begin errors++; $display("FAIL xor_rises got=%0d exp=2", rises); end
        checks++;
        if (cnt !== exp_cnt(2)) begin errors++; $display("FAIL xor_cnt got=%0d exp=%0d", cnt, exp_cnt(2)); end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] vec [5];
        logic expd [5];
        logic got [$];
        logic snap_o2, snap_v;
        logic [CNT_W-1:0] snap_cnt;
        logic e;
        int si;
        int rises;
        vec  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        expd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        si = 0;
        rises = 0;
        snap_o2 = 1'b0; snap_v = 1'b0; snap_cnt = '0;
        do_reset();
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            e = !(c >= 2 && c < 5);
            if (c == 2) begin
                snap_o2 = o2; snap_v = o2_valid; snap_cnt = cnt;
            end
            if (!e)           drive(1'b0, 1'b0, 2'b01, 3'b111, 1'b1);
            else if (si < 5)  begin drive(1'b0, 1'b1, 2'b01, vec[si], 1'b1); si++; end
            else              drive(1'b0, 1'b1, 2'b01, 3'b000, 1'b0);
            @(negedge clk);
            if (rise) rises++;
            if (!e) begin
                checks++;
                if ({o2, o2_valid, rise} !== {snap_o2, snap_v, 1'b0} || cnt !== snap_cnt) begin
                    errors++;
                    $display("FAIL stall_frozen got=%b cnt=%0d exp=%b cnt=%0d", {o2, o2_valid, rise}, cnt, {snap_o2, snap_v, 1'b0}, snap_cnt);
                end
            end else if (o2_valid) begin
                got.push_back(o2);
            end
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k] !== expd[k]) begin errors++; $display("FAIL stall_order idx=%0d got=%b exp=%b", k, got[k], expd[k]); end
            end
        end
        checks++;
        if (rises != 3 || cnt !== exp_cnt(3)) begin errors++; $display("FAIL stall_rises got=%0d cnt=%0d exp=3 cnt=%0d", rises, cnt, exp_cnt(3)); end
        drive(1'b0, 1'b1, 2'b01, 3'b000, 1'b0);
    endtask

    task automatic test_filter_mode();
        int rises;
        bit seen;
        rises = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       drive(1'b0, 1'b1, 2'b01, 3'b001, 1'b1);
                1:       drive(1'b0, 1'b1, 2'b01, 3'b000, 1'b0);
                2:       drive(1'b0, 1'b1, 2'b01, 3'b010, 1'b1);
                default: drive(1'b0, 1'b1, 2'b01, 3'b000, 1'b0);
            endcase
            @(negedge clk);
            if (rise) rises++;
        end
        checks++;
        if (rises != 1) begin errors++; $display("FAIL filter_rises got=%0d exp=1", rises); end
        // AND of 011 is 0; NAND of the same vector would be 1
        drive(1'b0, 1'b1, 2'b00, 3'b011, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b11, 3'b011, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b11, 3'b000, 1'b0);
        checks++;
        if ({o2, o2_valid, rise} !== 3'b010) begin errors++; $display("FAIL mode_inflight got=%b exp=010", {o2, o2_valid, rise}); end
        @(negedge clk);
        checks++;
        if ({o2, o2_valid, rise} !== 3'b100) begin errors++; $display("FAIL mode_invalid got=%b exp=100", {o2, o2_valid, rise}); end
        // The captured valid 0 re-armed detection
        drive(1'b0, 1'b1, 2'b01, 3'b001, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 3'b000, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rise) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rearm_rise got=0 exp=1"); end
    endtask

    task automatic test_saturation();
        logic [CNT_WS-1:0] sat_tab [5];
        int r;
        r = 0;
        sat_tab = '{exp_cnt_s(1), exp_cnt_s(2), exp_cnt_s(3), exp_cnt_s(4), exp_cnt_s(5)};
        do_reset();
        for (int c = 0; c < 30 && r < 5; c++) begin
            if (c < 10) drive(1'b0, 1'b1, 2'b00, (c % 2 == 0) ? 3'b111 : 3'b000, 1'b1);
            else        drive(1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
            @(negedge clk);
            if (rise) begin
                checks++;
                if (s_cnt !== sat_tab[r]) begin errors++; $display("FAIL sat_cnt rise=%0d got=%0d exp=%0d", r + 1, s_cnt, sat_tab[r]); end
                checks++;
                if (cnt !== exp_cnt(r + 1)) begin errors++; $display("FAIL wide_cnt rise=%0d got=%0d exp=%0d", r + 1, cnt, exp_cnt(r + 1)); end
                r++;
            end
        end
        checks++;
        if (r != 5) begin errors++; $display("FAIL sat_rises got=%0d exp=5", r); end
        // Put a sample in flight, then reset over it
        drive(1'b0, 1'b1, 2'b00, 3'b111, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1);
        @(negedge clk);
        checks++;
        if (s_cnt !== '0 || cnt !== '0 || {o2, o2_valid, rise} !== 3'b000) begin
            errors++;
            $display("FAIL sat_reset got cnt=%0d/%0d outs=%b exp 0/0 000", cnt, s_cnt, {o2, o2_valid, rise});
        end
        drive(1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o2_valid !== 1'b0) begin errors++; $display("FAIL flush_empty cyc=%0d got=%b exp=0", c, o2_valid); end
        end
    endtask

    initial begin
        drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1);
        test_reset();
        test_and_single();
        test_xor_seq();
        test_stall();
        test_filter_mode();
        test_saturation();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reduce_pipe.md
# reduce_pipe

- Parametrised successor to the team's single-bit wire/reduce/register primitive.
- Takes a WIDTH-bit input vector and provides three outputs: a pass-through copy, a combinational reduction with selectable mode, and that reduction delayed through a DEPTH-stage pipeline with valid tracking and stall.
- Adds rising-edge detection on the pipelined result and an optional saturating event counter.
- Used as a teaching and lab building block alongside other digitaljs examples.

## Interface

Parameters:
- WIDTH, 3, input vector width (>=2)
- DEPTH, 1, number of register stages on the pipelined path (>=1)
- CNT_W, 8, event counter width (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- en  input  1  pipeline advance; 0 stalls every register
- mode  input  2  reduction select: 00 AND, 01 OR, 10 XOR, 11 NAND
- i  input  WIDTH  data vector
- i_valid  input  1  marks i as a valid sample
- o0  output  WIDTH  wire copy of i
- o1  output  1  combinational reduction of i under the current mode
- o2  output  1  pipelined reduction (last stage)
- o2_valid  output  1  valid bit travelling with o2
- rise  output  1  one-cycle pulse on a valid 0->1 transition of o2
- cnt  output  CNT_W  saturating count of rise pulses

## Operation

- o0 = i and o1 = reduce(mode, i) are purely combinational, with no reset dependence.
- Stage 1 captures {reduce(mode, i), i_valid} on an edge with en=1.
  - mode is applied at capture time; samples already in flight are unaffected by later mode changes.
- Stage k (2..DEPTH) captures stage k-1 on an edge with en=1.
- o2 and o2_valid are the data and valid bits of stage DEPTH.
- en=0 holds all stages, last_o2, and cnt. rise is forced to 0 on that edge.
- Invalid samples (i_valid=0) still flow through the pipeline, but their data is ignored for edge detection.
- Edge detection:
  - A register last_o2 (reset 0) holds the data bit of the most recent valid sample to reach stage DEPTH.
  - On an en=1 edge where the value entering stage DEPTH is valid with data 1 and last_o2=0: rise<=1.
  - On every other edge: rise<=0.
  - last_o2 updates only when a valid sample enters stage DEPTH.
- Counter: on the same edge that sets rise, cnt<=cnt+1, unless cnt is all-ones. In that case cnt holds (saturates; it never wraps).

## Timing

- Reset values, applied at the first rising clk edge with rst=1: every stage data and valid bit = 0; o2=0, o2_valid=0, last_o2=0, rise=0, cnt=0.
- rst has priority over en.
- A reset mid-stream discards all in-flight samples.
- The first valid sample after reset that reduces to 1 produces a rise.
- Latency from i to o2/o2_valid: exactly DEPTH edges with en=1. Stalled edges add delay but lose no data.
- rise and the cnt increment become visible in the same cycle that the triggering sample appears on o2.
- Consecutive valid 1s produce a single rise. An invalid sample between them does not re-arm detection.
- o1 responds to changes in i or mode within the same cycle.

## Configuration

- Macro: REDUCE_PIPE_EVENT_CNT_EN.
- Defined: the CNT_W-bit saturating counter is built as described above.
- Undefined:
  - No counter flops are generated, and cnt is tied to 0.
  - rise and all other behaviour are unchanged.

## Test plan

Unless a line says otherwise: WIDTH=3, DEPTH=2, CNT_W=8, macro defined, en=1.

- **Reset:** hold rst=1 for 2 cycles with i=111, i_valid=1.
  - Required: o2=0, o2_valid=0, rise=0, cnt=0.
  - Required: o0=111 and o1=1 throughout.
- **AND mode, single sample:** mode=00; drive i=111, i_valid=1 for one cycle, then i_valid=0.
  - Required: o1=1 immediately.
  - Required: o2=1 and o2_valid=1 after 2 edges, with rise=1 for exactly one cycle and cnt=1.
- **XOR sequence:** mode=10; drive valid i=001, 011, 111 on consecutive cycles.
  - Required: o2 shows 1, 0, 1 starting 2 cycles later.
  - Required: rise pulses twice; cnt=2.
- **Stall:** mid-sequence, set en=0 for 3 cycles.
  - Required: o2, o2_valid, and cnt frozen; rise=0.
  - Required: after en returns to 1, the remaining samples emerge in order with none lost.
- **Valid filtering and mode switch:** drive a valid 1, then an invalid 0, then a valid 1 (mode=01).
  - Required: one rise only.
  - Then switch mode to 11 while a sample is in flight. Required: the in-flight result keeps its captured mode.
- **Saturation and build variant:** CNT_W=2; generate 5 rises.
  - Required: cnt reads 1, 2, 3, 3, 3.
  - Then assert rst for one cycle. Required: cnt=0 and the pipeline is empty.
  - Rebuild with the macro undefined. Required: cnt stays 0 and rise behaviour is identical.
